// File: rtl/puf_pkg.sv
// Shared types and default timing for the arbiter-PUF vote sequencer.
package puf_pkg;

    localparam int PUF_WIDTH = 8;

    localparam int DEF_NUM_VOTES  = 5;
    localparam int DEF_SETTLE_CYC = 4;
    localparam int DEF_PULSE_CYC  = 4;
    localparam int DEF_LOW_CYC    = 4;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        PULSE,
        LOW,
        DONE
    } puf_state_e;

endpackage

// File: rtl/puf_vote_sequencer_if.sv
// Host-side request/response bundle of the PUF vote sequencer.
// PUF_UNSTABLE_MASK_EN adds the per-bit non-unanimous mask.
interface puf_vote_sequencer_if;
    import puf_pkg::*;

    logic                 start;
    logic [PUF_WIDTH-1:0] challenge_in;
    logic [PUF_WIDTH-1:0] resp_out;
    logic                 resp_valid;
    logic                 busy;
`ifdef PUF_UNSTABLE_MASK_EN
    logic [PUF_WIDTH-1:0] unstable_mask;

    modport master (
        output start, challenge_in,
        input  resp_out, resp_valid, busy, unstable_mask
    );
    modport slave (
        input  start, challenge_in,
        output resp_out, resp_valid, busy, unstable_mask
    );
`else
    modport master (
        output start, challenge_in,
        input  resp_out, resp_valid, busy
    );
    modport slave (
        input  start, challenge_in,
        output resp_out, resp_valid, busy
    );
`endif

endinterface

// File: rtl/puf_resp_sync.sv
// Two-flop synchronizer bringing the asynchronous PUF response into the clk domain.
module puf_resp_sync
    import puf_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PUF_WIDTH-1:0] async_in,
    output logic [PUF_WIDTH-1:0] sync_out
);

    logic [PUF_WIDTH-1:0] meta_q;

    // NOTE: sequential state uses non-blocking assignments so both flops
    // sample the pre-edge values and the chain really is two stages deep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q   <= '0;
            sync_out <= '0;
        end else begin
            meta_q   <= async_in;
            sync_out <= meta_q;
        end
    end

endmodule

// File: rtl/puf_vote_sequencer.sv
// Drives challenge and race pulse into the arbiter-PUF array, repeats the
// evaluation NUM_VOTES times and emits a per-bit majority-voted response.
// Optional macro PUF_UNSTABLE_MASK_EN adds the unstable_mask output.
module puf_vote_sequencer
    import puf_pkg::*;
#(
    parameter int NUM_VOTES  = DEF_NUM_VOTES,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int PULSE_CYC  = DEF_PULSE_CYC,
    parameter int LOW_CYC    = DEF_LOW_CYC
) (
    input  logic                 clk,
    input  logic                 rst_n,
    puf_vote_sequencer_if.slave  host,
    input  logic [PUF_WIDTH-1:0] puf_resp,
    output logic [PUF_WIDTH-1:0] puf_challenge,
    output logic                 puf_pulse
);

    localparam int CW      = $clog2(NUM_VOTES + 1);
    localparam int MAX_CYC = (SETTLE_CYC > PULSE_CYC)
                           ? ((SETTLE_CYC > LOW_CYC) ? SETTLE_CYC : LOW_CYC)
                           : ((PULSE_CYC > LOW_CYC) ? PULSE_CYC : LOW_CYC);
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    generate
        if (NUM_VOTES < 1 || (NUM_VOTES % 2) == 0) begin : g_bad_votes
            $error("puf_vote_sequencer: NUM_VOTES must be odd and >= 1");
        end
        if (SETTLE_CYC < 1 || LOW_CYC < 1) begin : g_bad_gap
            $error("puf_vote_sequencer: SETTLE_CYC and LOW_CYC must be >= 1");
        end
        if (PULSE_CYC < 3) begin : g_bad_pulse
            $error("puf_vote_sequencer: PULSE_CYC must be >= 3");
        end
    endgenerate

    puf_state_e           state;
    logic [TW-1:0]        timer;
    logic [CW-1:0]        vote_idx;
    logic [CW-1:0]        counts     [PUF_WIDTH];
    logic [CW-1:0]        counts_inc [PUF_WIDTH];
    logic [PUF_WIDTH-1:0] resp_sync;
    logic [PUF_WIDTH-1:0] vote_bits;
    logic [PUF_WIDTH-1:0] resp_out_q;
    logic                 resp_valid_q;
    logic                 busy_q;

    // Only the synchronized copy of the response is visible past this point.
    puf_resp_sync u_resp_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (puf_resp),
        .sync_out (resp_sync)
    );

`ifdef PUF_UNSTABLE_MASK_EN
    logic [PUF_WIDTH-1:0] mask_bits;
    logic [PUF_WIDTH-1:0] mask_q;
`endif

    // Counts including the sample taken on the last pulse cycle, so the
    // vote can be registered on the same edge that enters DONE.
    // NOTE: every always_comb output gets a default before any condition,
    // so no path can leave it unassigned and infer a latch.
    always_comb begin
        vote_bits = '0;
`ifdef PUF_UNSTABLE_MASK_EN
        mask_bits = '0;
`endif
        for (int i = 0; i < PUF_WIDTH; i++) begin
            counts_inc[i] = counts[i] + CW'(resp_sync[i]);
            vote_bits[i]  = (counts_inc[i] > CW'(NUM_VOTES / 2));
`ifdef PUF_UNSTABLE_MASK_EN
            mask_bits[i]  = (counts_inc[i] != '0) && (counts_inc[i] != CW'(NUM_VOTES));
`endif
        end
    end

    // NOTE: the vote counters are a handful of flops, not a RAM, so they are
    // cleared by reset like any other state and a partial vote cannot leak.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            timer         <= '0;
            vote_idx      <= '0;
            for (int i = 0; i < PUF_WIDTH; i++) counts[i] <= '0;
            puf_challenge <= '0;
            puf_pulse     <= 1'b0;
            resp_out_q    <= '0;
            resp_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
`ifdef PUF_UNSTABLE_MASK_EN
            mask_q        <= '0;
`endif
        end else begin
            resp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (host.start) begin
                        puf_challenge <= host.challenge_in;
                        for (int i = 0; i < PUF_WIDTH; i++) counts[i] <= '0;
                        vote_idx      <= '0;
                        timer         <= TW'(SETTLE_CYC - 1);
                        busy_q        <= 1'b1;
                        state         <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (timer == '0) begin
                        timer     <= TW'(PULSE_CYC - 1);
                        puf_pulse <= 1'b1;
                        state     <= PULSE;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                PULSE: begin
                    if (timer == '0) begin
                        counts    <= counts_inc;
                        vote_idx  <= vote_idx + CW'(1);
                        puf_pulse <= 1'b0;
                        if (vote_idx == CW'(NUM_VOTES - 1)) begin
                            resp_out_q   <= vote_bits;
                            resp_valid_q <= 1'b1;
`ifdef PUF_UNSTABLE_MASK_EN
                            mask_q       <= mask_bits;
`endif
                            state        <= DONE;
                        end else begin
                            timer <= TW'(LOW_CYC - 1);
                            state <= LOW;
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                LOW: begin
                    if (timer == '0) begin
                        timer     <= TW'(PULSE_CYC - 1);
                        puf_pulse <= 1'b1;
                        state     <= PULSE;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    puf_pulse <= 1'b0;
                    busy_q    <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign host.resp_out   = resp_out_q;
    assign host.resp_valid = resp_valid_q;
    assign host.busy       = busy_q;
`ifdef PUF_UNSTABLE_MASK_EN
    assign host.unstable_mask = mask_q;
`endif

endmodule

// File: tb/tb_puf_vote_sequencer.sv
// Self-checking bench: default 5-vote build plus a 1-vote/1-settle/3-pulse build,
// each fed by a behavioural PUF stub and checked against a majority-vote model.
`timescale 1ns/1ps
module tb_puf_vote_sequencer;
    import puf_pkg::*;

    localparam int NV    = 5;
    localparam int S     = 4;
    localparam int P     = 4;
    localparam int L     = 4;
    localparam int LAT   = 1 + S + NV * P + (NV - 1) * L;
    localparam int S_B   = 1;
    localparam int P_B   = 3;
    localparam int LAT_B = 1 + S_B + P_B;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    puf_vote_sequencer_if a_if ();
    puf_vote_sequencer_if b_if ();

    logic [7:0] a_resp = 8'h00;
    logic [7:0] a_chal;
    logic       a_pulse;
    logic [7:0] b_resp = 8'h00;
    logic [7:0] b_chal;
    logic       b_pulse;
    logic [7:0] a_seq[$];
    logic [7:0] b_seq[$];

    puf_vote_sequencer #(
        .NUM_VOTES(NV), .SETTLE_CYC(S), .PULSE_CYC(P), .LOW_CYC(L)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .host(a_if),
        .puf_resp(a_resp), .puf_challenge(a_chal), .puf_pulse(a_pulse)
    );

    puf_vote_sequencer #(
        .NUM_VOTES(1), .SETTLE_CYC(S_B), .PULSE_CYC(P_B), .LOW_CYC(L)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .host(b_if),
        .puf_resp(b_resp), .puf_challenge(b_chal), .puf_pulse(b_pulse)
    );

    // PUF stubs: next scripted response on each rising pulse, noise when it falls.
    always @(a_pulse) begin
        #1;
        if (a_pulse === 1'b1) a_resp = (a_seq.size() > 0) ? a_seq.pop_front() : 8'h00;
        else                  a_resp = 8'($urandom);
    end

    always @(b_pulse) begin
        #1;
        if (b_pulse === 1'b1) b_resp = (b_seq.size() > 0) ? b_seq.pop_front() : 8'h00;
        else                  b_resp = 8'($urandom);
    end

    function automatic logic [7:0] vote_model(input logic [7:0] v [NV]);
        logic [7:0] r;
        r = '0;
        for (int b = 0; b < 8; b++) begin
            int ones;
            ones = 0;
            for (int k = 0; k < NV; k++) ones += int'(v[k][b]);
            r[b] = (2 * ones > NV);
        end
        return r;
    endfunction

    function automatic logic [7:0] unstable_model(input logic [7:0] v [NV]);
        logic [7:0] r;
        r = '0;
        for (int b = 0; b < 8; b++) begin
            int ones;
            ones = 0;
            for (int k = 0; k < NV; k++) ones += int'(v[k][b]);
            r[b] = (ones != 0) && (ones != NV);
        end
        return r;
    endfunction

    // One evaluation on DUT a, with an optional extra start injected at cycle inj_cyc.
    // Pulse shape and challenge hold are checked every cycle of the window.
    task automatic a_run(input logic [7:0] chal, input logic [7:0] votes [NV],
                         input int inj_cyc, input logic [7:0] inj_chal,
                         output int valid_cyc, output int nvalid, output logic [7:0] resp,
                         output logic [7:0] mask, output logic [7:0] chal_seen,
                         output logic busy_after, output int rises);
        logic pp;
        int   hi;
        int   lo;
        @(negedge clk);
        a_seq.delete();
        for (int k = 0; k < NV; k++) a_seq.push_back(votes[k]);
        a_if.start        = 1'b1;
        a_if.challenge_in = chal;
        @(posedge clk);
        #1;
        a_if.start        = 1'b0;
        a_if.challenge_in = 8'($urandom);
        valid_cyc = -1; nvalid = 0; resp = '0; mask = '0; chal_seen = '0;
        busy_after = 1'b1; rises = 0; pp = 1'b0; hi = 0; lo = 0;
        for (int cyc = 1; cyc <= LAT + 4; cyc++) begin
            @(negedge clk);
            a_if.start = 1'b0;
            if (cyc == inj_cyc) begin
                a_if.start        = 1'b1;
                a_if.challenge_in = inj_chal;
            end
            if (cyc == 1) chal_seen = a_chal;
            if (a_if.resp_valid === 1'b1) begin
                nvalid++;
                if (valid_cyc < 0) begin
                    valid_cyc = cyc;
                    resp      = a_if.resp_out;
`ifdef PUF_UNSTABLE_MASK_EN
                    mask      = a_if.unstable_mask;
`endif
                end
            end
            if (cyc == LAT + 1) busy_after = a_if.busy;
            if (a_pulse === 1'b1) begin
                if (!pp) begin
                    rises++;
                    checks++;
                    if (lo != ((rises == 1) ? S : L)) begin
                        errors++;
                        $display("FAIL a_low_before_rise: rise %0d after %0d low cycles, expected %0d",
                                 rises, lo, (rises == 1) ? S : L);
                    end
                    lo = 0;
                end
                hi++;
            end else begin
                if (pp) begin
                    checks++;
                    if (hi != P) begin
                        errors++;
                        $display("FAIL a_pulse_width: got %0d cycles, expected %0d", hi, P);
                    end
                    hi = 0;
                end
                if (a_if.busy === 1'b1) lo++;
            end
            pp = a_pulse;
            if (a_if.busy === 1'b1) begin
                checks++;
                if (a_chal !== chal) begin
                    errors++;
                    $display("FAIL a_chal_hold: cycle %0d got %h, expected %h", cyc, a_chal, chal);
                end
            end
        end
        a_if.start = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (a_chal !== 8'h00)       begin errors++; $display("FAIL reset_chal: got %h, expected 00", a_chal); end
        checks++; if (a_pulse !== 1'b0)       begin errors++; $display("FAIL reset_pulse: got %b, expected 0", a_pulse); end
        checks++; if (a_if.resp_out !== 8'h00) begin errors++; $display("FAIL reset_resp: got %h, expected 00", a_if.resp_out); end
        checks++; if (a_if.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", a_if.resp_valid); end
        checks++; if (a_if.busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b, expected 0", a_if.busy); end
        checks++; if (b_pulse !== 1'b0 || b_if.busy !== 1'b0 || b_chal !== 8'h00)
                  begin errors++; $display("FAIL reset_b: pulse=%b busy=%b chal=%h, expected 0/0/00", b_pulse, b_if.busy, b_chal); end
`ifdef PUF_UNSTABLE_MASK_EN
        checks++; if (a_if.unstable_mask !== 8'h00) begin errors++; $display("FAIL reset_mask: got %h, expected 00", a_if.unstable_mask); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_stable();
        logic [7:0] v [NV];
        int vc, nv, rs;
        logic [7:0] r, m, cs;
        logic ba;
        v = '{8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C};
        a_run(8'hA5, v, 0, 8'h00, vc, nv, r, m, cs, ba, rs);
        checks++; if (cs !== 8'hA5)  begin errors++; $display("FAIL stable_chal: got %h, expected a5", cs); end
        checks++; if (vc != LAT)     begin errors++; $display("FAIL stable_latency: got %0d, expected %0d", vc, LAT); end
        checks++; if (nv != 1)       begin errors++; $display("FAIL stable_nvalid: got %0d, expected 1", nv); end
        checks++; if (r !== 8'h3C)   begin errors++; $display("FAIL stable_resp: got %h, expected 3c", r); end
        checks++; if (ba !== 1'b0)   begin errors++; $display("FAIL stable_busy_after: got %b, expected 0", ba); end
        checks++; if (rs != NV)      begin errors++; $display("FAIL stable_pulses: got %0d, expected %0d", rs, NV); end
`ifdef PUF_UNSTABLE_MASK_EN
        checks++; if (m !== 8'h00)   begin errors++; $display("FAIL stable_mask: got %h, expected 00", m); end
`endif
    endtask

    task automatic test_majority();
        logic [7:0] v [NV];
        int vc, nv, rs;
        logic [7:0] r, m, cs;
        logic ba;
        v = '{8'h01, 8'h00, 8'h81, 8'h80, 8'h01};
        a_run(8'h5C, v, 0, 8'h00, vc, nv, r, m, cs, ba, rs);
        checks++; if (r[0] !== 1'b1 || r[7] !== 1'b0)
                  begin errors++; $display("FAIL majority_bits: got bit0=%b bit7=%b, expected 1/0", r[0], r[7]); end
        checks++; if (r !== vote_model(v)) begin errors++; $display("FAIL majority_resp: got %h, expected %h", r, vote_model(v)); end
`ifdef PUF_UNSTABLE_MASK_EN
        checks++; if (m !== 8'h81) begin errors++; $display("FAIL majority_mask: got %h, expected 81", m); end
`endif
    endtask

    task automatic test_start_while_busy();
        logic [7:0] v [NV];
        int vc, nv, rs;
        logic [7:0] r, m, cs;
        logic ba;
        v = '{8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C};
        a_run(8'hA5, v, 10, 8'hFF, vc, nv, r, m, cs, ba, rs);
        checks++; if (nv != 1 || vc != LAT) begin errors++; $display("FAIL busy_start_valid: got %0d strobes at %0d, expected 1 at %0d", nv, vc, LAT); end
        checks++; if (r !== 8'h3C) begin errors++; $display("FAIL busy_start_resp: got %h, expected 3c", r); end
        a_run(8'hA5, v, LAT, 8'hFF, vc, nv, r, m, cs, ba, rs);
        checks++; if (ba !== 1'b0) begin errors++; $display("FAIL done_start_busy: got %b, expected 0", ba); end
        checks++; if (nv != 1)     begin errors++; $display("FAIL done_start_nvalid: got %0d, expected 1", nv); end
        repeat (3) @(negedge clk);
        checks++; if (a_if.busy !== 1'b0) begin errors++; $display("FAIL done_start_queued: busy=%b, expected 0", a_if.busy); end
    endtask

    task automatic test_reset_mid_pulse();
        logic [7:0] v [NV];
        int vc, nv, rs, rises;
        logic [7:0] r, m, cs;
        logic ba, pp, seen;
        @(negedge clk);
        a_seq.delete();
        for (int k = 0; k < NV; k++) a_seq.push_back(8'h5A);
        a_if.start = 1'b1; a_if.challenge_in = 8'h66;
        @(posedge clk);
        #1 a_if.start = 1'b0;
        rises = 0; pp = 1'b0; seen = 1'b0;
        for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
            @(negedge clk);
            if (a_pulse === 1'b1 && !pp) rises++;
            pp = a_pulse;
            if (rises == 3) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL rst_wait_third_pulse: saw %0d rises, expected 3", rises); end
        @(negedge clk);
        checks++; if (a_pulse !== 1'b1) begin errors++; $display("FAIL rst_pre_pulse: got %b, expected 1", a_pulse); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (a_pulse !== 1'b0) begin errors++; $display("FAIL rst_async_pulse: got %b, expected 0", a_pulse); end
        checks++; if (a_chal !== 8'h00 || a_if.resp_out !== 8'h00 || a_if.resp_valid !== 1'b0 || a_if.busy !== 1'b0)
                  begin errors++; $display("FAIL rst_outputs: chal=%h resp=%h valid=%b busy=%b, expected all 0",
                                           a_chal, a_if.resp_out, a_if.resp_valid, a_if.busy); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < NV; k++) v[k] = 8'($urandom);
        a_run(8'h99, v, 0, 8'h00, vc, nv, r, m, cs, ba, rs);
        checks++; if (vc != LAT || nv != 1) begin errors++; $display("FAIL rst_rerun_valid: got %0d strobes at %0d, expected 1 at %0d", nv, vc, LAT); end
        checks++; if (r !== vote_model(v)) begin errors++; $display("FAIL rst_rerun_resp: got %h, expected %h", r, vote_model(v)); end
    endtask

    task automatic test_single_vote();
        logic [7:0] exp_r;
        int vc, nv, rises;
        logic [7:0] r;
        logic pp, ba;
        for (int it = 0; it < 4; it++) begin
            exp_r = (it == 0) ? 8'hC3 : 8'($urandom);
            @(negedge clk);
            b_seq.delete();
            b_seq.push_back(exp_r);
            b_if.start = 1'b1; b_if.challenge_in = 8'($urandom);
            @(posedge clk);
            #1 b_if.start = 1'b0;
            vc = -1; nv = 0; r = '0; rises = 0; pp = 1'b0; ba = 1'b1;
            for (int cyc = 1; cyc <= LAT_B + 3; cyc++) begin
                @(negedge clk);
                if (b_pulse === 1'b1 && !pp) rises++;
                pp = b_pulse;
                if (b_if.resp_valid === 1'b1) begin
                    nv++;
                    if (vc < 0) begin vc = cyc; r = b_if.resp_out; end
                end
                if (cyc == LAT_B + 1) ba = b_if.busy;
            end
            checks++; if (vc != LAT_B || nv != 1) begin errors++; $display("FAIL single_valid: got %0d strobes at %0d, expected 1 at %0d", nv, vc, LAT_B); end
            checks++; if (r !== exp_r) begin errors++; $display("FAIL single_resp: got %h, expected %h", r, exp_r); end
            checks++; if (rises != 1 || ba !== 1'b0) begin errors++; $display("FAIL single_no_low: rises=%0d busy_after=%b, expected 1/0", rises, ba); end
        end
    endtask

    task automatic test_random();
        logic [7:0] v [NV];
        logic [7:0] chal;
        int vc, nv, rs;
        logic [7:0] r, m, cs;
        logic ba;
        for (int it = 0; it < 100; it++) begin
            chal = 8'($urandom);
            for (int k = 0; k < NV; k++) v[k] = 8'($urandom);
            a_run(chal, v, 0, 8'h00, vc, nv, r, m, cs, ba, rs);
            checks++;
            if (r !== vote_model(v) || vc != LAT || nv != 1 || cs !== chal) begin
                errors++;
                $display("FAIL random_%0d: resp=%h lat=%0d nvalid=%0d chal=%h, expected resp=%h lat=%0d nvalid=1 chal=%h",
                         it, r, vc, nv, cs, vote_model(v), LAT, chal);
            end
`ifdef PUF_UNSTABLE_MASK_EN
            checks++;
            if (m !== unstable_model(v)) begin
                errors++;
                $display("FAIL random_mask_%0d: got %h, expected %h", it, m, unstable_model(v));
            end
`endif
        end
    endtask

    initial begin
        a_if.start = 1'b0; a_if.challenge_in = 8'h00;
        b_if.start = 1'b0; b_if.challenge_in = 8'h00;
        test_reset();
        test_stable();
        test_majority();
        test_start_while_busy();
        test_reset_mid_pulse();
        test_single_vote();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/puf_vote_sequencer.md
Name: puf_vote_sequencer

Overview:
- Control stage wrapped around the 8-bit arbiter-PUF array.
- Latches a challenge and drives it onto the array's challenge inputs, then generates the race pulse that feeds the array's pulse input.
- Captures the asynchronous 8-bit response through a 2-flop synchronizer and repeats the evaluation NUM_VOTES times.
- Outputs a per-bit majority-voted response with a valid strobe.

Parameters:
- NUM_VOTES, 5: evaluations per challenge. Must be odd, ≥1; elaboration error otherwise.
- SETTLE_CYC, 4: cycles the challenge is held with pulse low before the first rising edge. ≥1.
- PULSE_CYC, 4: cycles puf_pulse is high per evaluation. ≥3, to cover the synchronizer.
- LOW_CYC, 4: cycles puf_pulse is low between evaluations. ≥1.
- CW, $clog2(NUM_VOTES+1): width of each per-bit ones counter (localparam).

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: request evaluation. Sampled only in IDLE.
- challenge_in, input, 8: challenge, captured on the accepted start.
- puf_resp, input, 8: raw response from the PUF array. Asynchronous to clk.
- puf_challenge, output, 8: registered challenge to the PUF array.
- puf_pulse, output, 1: registered race pulse to the PUF array.
- resp_out, output, 8: majority-voted response. Held until the next DONE.
- resp_valid, output, 1: one-cycle strobe when resp_out updates.
- busy, output, 1: high in every state except IDLE.

Behaviour:
- Clock/reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: puf_challenge=0, puf_pulse=0, resp_out=0, resp_valid=0, busy=0, state=IDLE. Counters, synchronizer flops and vote counters all cleared.
- FSM states: IDLE, SETTLE, PULSE, LOW, DONE.
- IDLE:
  - start=1 at edge t: puf_challenge<=challenge_in, vote counters cleared, vote index=0, go to SETTLE.
  - busy=1 from t+1.
  - start=0: stay in IDLE.
- SETTLE: puf_pulse=0 for SETTLE_CYC cycles, then go to PULSE.
- PULSE:
  - puf_pulse=1 for PULSE_CYC cycles.
  - On the last PULSE cycle, each bit counter i increments if synced puf_resp[i]=1. Vote index increments.
  - If vote index < NUM_VOTES, go to LOW. Otherwise go to DONE.
- LOW: puf_pulse=0 for LOW_CYC cycles, then go to PULSE.
- DONE:
  - puf_pulse=0.
  - resp_out[i] <= (count[i] > NUM_VOTES/2), registered.
  - resp_valid=1 for exactly this cycle, then go to IDLE.
- Latency: resp_valid is high in cycle t+1+SETTLE_CYC+NUM_VOTES*PULSE_CYC+(NUM_VOTES-1)*LOW_CYC. With defaults this is t+41.
- Input isolation:
  - start while busy, including the DONE cycle, is ignored and not queued.
  - challenge_in changes after capture are ignored.
  - puf_challenge is stable for the whole busy window.
- puf_pulse is always low for ≥1 cycle before every rising edge.
- Counters never overflow; CW is sized for NUM_VOTES.
- NUM_VOTES=1: a single evaluation, no LOW state visited.
- Reset mid-operation: puf_pulse drops asynchronously. The partial vote is discarded and resp_out returns to 0.
- puf_resp is only used after the synchronizer. No raw puf_resp bit reaches any logic other than the first sync flop.

Optional Feature:
- Macro: PUF_UNSTABLE_MASK_EN.
- Defined:
  - Adds output port unstable_mask [7:0], reset 0.
  - Updated in DONE alongside resp_out.
  - unstable_mask[i]=1 when count[i] is neither 0 nor NUM_VOTES, i.e. the bit was not unanimous.
  - Used for helper-data and reliability characterization.
- Undefined: port and its logic are absent. Everything else is identical.

Decomposition:
- Shared package puf_pkg holds:
  - the state enum: IDLE, SETTLE, PULSE, LOW, DONE;
  - PUF_WIDTH=8;
  - default timing constants.
- One sub-module, puf_resp_sync: 2-flop synchronizer, PUF_WIDTH wide, async reset.
- Vote counters and FSM stay in the top module.

Test Plan:
- Stable response: behavioural PUF stub returns 0x3C on each pulse rise. start with challenge_in=0xA5 at t → puf_challenge=0xA5 from t+1; resp_out=0x3C and resp_valid=1 exactly at t+41; busy low at t+42; five puf_pulse high periods of 4 cycles each.
- Majority vote: stub bit0 sequence 1,0,1,0,1 and bit7 sequence 0,0,1,1,0 → resp_out[0]=1, resp_out[7]=0. With PUF_UNSTABLE_MASK_EN defined, unstable_mask=0x81.
- Start while busy: second start at t+10 with challenge_in=0xFF → ignored; puf_challenge stays 0xA5; exactly one resp_valid. A start in the DONE cycle is also ignored.
- Reset mid-pulse: assert rst_n=0 during the third PULSE → puf_pulse=0 with no clk edge; all outputs 0. A new start after release completes normally at t'+41.
- NUM_VOTES=1, SETTLE_CYC=1, PULSE_CYC=3 build: stub returns 0xC3 → resp_valid at t+5, resp_out=0xC3, no LOW cycles seen.
- Pulse hygiene (assertion): across a 100-random-challenge run, puf_pulse is low the cycle before every rise, and puf_challenge never changes while busy=1.
